ahbl_bus_splitter: RTL

AHBL_BUS_SPLITTER -- requirements
Module: ahbl_bus_splitter

---
 rtl/ahbl_bus_splitter.sv | 103 ++++++++++
 1 files changed

// File: rtl/ahbl_bus_splitter.sv
// ahbl_bus_splitter: AHB-Lite address decoder and response multiplexer with an
// internal default slave and a slave wait-state watchdog.
//
// Ports:
//   HCLK, HRESETn     clock (rising edge) and asynchronous active-low reset
//   HADDR, HTRANS     master address and transfer type
//   HREADY            bus ready, driven to the master and all slaves
//   HRDATA, HRESP     read data and response to the master
//   S_HSEL            one-hot slave selects (combinational decode)
//   S_HRDATA          packed slave read data, slave i at [i*32 +: 32]
//   S_HREADYOUT       per-slave ready
//   S_HRESP           per-slave response
//   ERR_CNT           saturating count of splitter-generated error responses
module ahbl_bus_splitter #(
    parameter int                  NS        = 4,
    parameter int                  DEC_MSB   = 31,
    parameter int                  DEC_W     = 4,
    parameter logic [NS*DEC_W-1:0] S_MAP     = {4'h5, 4'h4, 4'h2, 4'h0},
    parameter int                  TIMEOUT   = 16,
    parameter logic [31:0]         DEAD_DATA = 32'hBADDBEEF
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    output logic             HREADY,
    output logic [31:0]      HRDATA,
    output logic             HRESP,
    output logic [NS-1:0]    S_HSEL,
    input  logic [NS*32-1:0] S_HRDATA,
    input  logic [NS-1:0]    S_HREADYOUT,
    input  logic [NS-1:0]    S_HRESP,
    output logic [7:0]       ERR_CNT
);
    localparam int IDX_W = $clog2(NS);
    localparam int WC_W  = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0] IDLE = 2'd0, ERR1 = 2'd1, ERR2 = 2'd2;

    logic [DEC_W-1:0] f;
    logic [NS-1:0]    match;
    logic [IDX_W-1:0] sel_idx, dp_idx;
    logic             dp_slv;
    logic [1:0]       fsm;
    logic [WC_W-1:0]  wc;
    logic             err, pass, slv_rdy, stall, accept, miss, to;
    logic             unused_ok;

    assign f = HADDR[DEC_MSB -: DEC_W];

    genvar i;
    generate
        for (i = 0; i < NS; i++) begin : g_match
            assign match[i] = f == S_MAP[i*DEC_W +: DEC_W];
        end
    endgenerate

    // Keep only the lowest set bit so overlapping regions resolve to the lowest index.
    assign S_HSEL = match & (~match + NS'(1));

    always_comb begin
        sel_idx = '0;
        for (int k = 0; k < NS; k++)
            if (S_HSEL[k]) sel_idx = IDX_W'(k);
    end

    // The default-slave owner needs no storage of its own: loading it always
    // starts the error sequence, which then drives every output.
    assign err     = fsm != IDLE;
    assign pass    = !err && dp_slv;
    assign slv_rdy = S_HREADYOUT[dp_idx];

    assign HREADY = fsm == ERR1 ? 1'b0 : pass ? slv_rdy : 1'b1;
    assign HRESP  = err | (pass & S_HRESP[dp_idx]);
    assign HRDATA = err ? DEAD_DATA : pass ? S_HRDATA[dp_idx*32 +: 32] : 32'h0;

    assign accept = HREADY & HTRANS[1];
    assign miss   = accept & ~|match;
    assign stall  = pass & ~slv_rdy;
    // Fires on the last allowed wait cycle, so a slave that is ready in that
    // cycle still completes normally.
    assign to     = (TIMEOUT != 0) && stall && (wc == WC_W'(TIMEOUT - 1));

    assign unused_ok = ^{HTRANS[0], HADDR};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_slv  <= 1'b0;
            dp_idx  <= '0;
            fsm     <= IDLE;
            wc      <= '0;
            ERR_CNT <= 8'h0;
        end else begin
            if (HREADY) begin
                dp_slv <= accept & |match;
                dp_idx <= sel_idx;
            end
            wc  <= (HREADY || to) ? '0 : stall ? wc + 1'b1 : wc;
            fsm <= (miss || to) ? ERR1 : fsm == ERR1 ? ERR2 : IDLE;
            if (fsm == ERR2 && ERR_CNT != 8'hFF)
                ERR_CNT <= ERR_CNT + 1'b1;
        end
    end
endmodule
